// File: rtl/edge_event_arbiter.sv
// Rising-edge event capture with per-channel pending/overflow flags and a
// round-robin valid/ready offer of one pending channel index at a time.
module edge_event_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] mask,
  input  logic             clear,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [IDXW-1:0]  evt_idx,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  localparam logic [IDXW-1:0] LAST_CH = IDXW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] in_q_reg;
  logic [WIDTH-1:0] pending_reg, pending_next;
  logic [WIDTH-1:0] overflow_reg, overflow_next;
  logic [IDXW-1:0]  evt_idx_reg, evt_idx_next;
  logic [IDXW-1:0]  last_grant_reg, last_grant_next;
  logic [WIDTH-1:0] rise, acc_vec, remain;
  logic             accept;

  // First set bit of req strictly after base, ascending with wrap-around.
  function automatic logic [IDXW-1:0] rr_pick(input logic [WIDTH-1:0] req,
                                               input logic [IDXW-1:0]  base);
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] c;
    pick = '0;
    for (int k = WIDTH; k >= 1; k--) begin
      c = IDXW'((int'(base) + k) % WIDTH);
      if (req[c]) pick = c;
    end
    return pick;
  endfunction

  assign accept = (state_reg == OFFER) && evt_ready;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      assign acc_vec[gi] = accept && (evt_idx_reg == IDXW'(gi));
      assign rise[gi]    = in[gi] & ~in_q_reg[gi] & mask[gi];
      // A rise coinciding with its own accept is a fresh event, not a merge.
      assign pending_next[gi]  = clear ? 1'b0
                               : (rise[gi] | (pending_reg[gi] & ~acc_vec[gi]));
      assign overflow_next[gi] = clear ? 1'b0
                               : (overflow_reg[gi] | (rise[gi] & pending_reg[gi] & ~acc_vec[gi]));
    end
  endgenerate

  assign remain = pending_reg & ~acc_vec;

  always_comb begin
    state_next      = state_reg;
    evt_idx_next    = evt_idx_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (|pending_reg) begin
          state_next   = OFFER;
          evt_idx_next = rr_pick(pending_reg, last_grant_reg);
        end
      end
      OFFER: begin
        if (accept) begin
          last_grant_next = evt_idx_reg;
          if (|remain) begin
            evt_idx_next = rr_pick(remain, evt_idx_reg);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (clear) begin
      state_next      = IDLE;
      evt_idx_next    = '0;
      last_grant_next = LAST_CH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      in_q_reg       <= '0;
      pending_reg    <= '0;
      overflow_reg   <= '0;
      evt_idx_reg    <= '0;
      last_grant_reg <= LAST_CH;
    end else begin
      state_reg      <= state_next;
      in_q_reg       <= in;
      pending_reg    <= pending_next;
      overflow_reg   <= overflow_next;
      evt_idx_reg    <= evt_idx_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign evt_valid = (state_reg == OFFER);
  assign evt_idx   = evt_idx_reg;
  assign pending   = pending_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all compared each cycle against a behavioural model.
module tb_edge_event_arbiter;

  localparam int WIDTH = 8;
  localparam int IDXW  = 3;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic [WIDTH-1:0] in_sig    = '0;
  logic [WIDTH-1:0] mask      = '0;
  logic             clear     = 1'b0;
  logic             evt_ready = 1'b0;
  logic             evt_valid;
  logic [IDXW-1:0]  evt_idx;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] overflow;

  int n_checks = 0;
  int n_fail   = 0;

  edge_event_arbiter #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in_sig),
    .mask     (mask),
    .clear    (clear),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_idx  (evt_idx),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_in_q = '0, m_pend = '0, m_ovf = '0;
  logic             m_valid = 1'b0;
  int               m_idx = 0, m_last = WIDTH - 1;

  logic [WIDTH-1:0] n_in_q, n_pend, n_ovf, others;
  logic             n_valid, acc;
  int               n_idx, n_last;

  function automatic int search(input logic [WIDTH-1:0] req, input int start);
    int res;
    int c;
    res = -1;
    for (int s = 1; s <= WIDTH; s++) begin
      c = (start + s) % WIDTH;
      if (res < 0 && req[c]) res = c;
    end
    return res;
  endfunction

  always_comb begin
    n_in_q  = in_sig;
    n_pend  = m_pend;
    n_ovf   = m_ovf;
    n_valid = m_valid;
    n_idx   = m_idx;
    n_last  = m_last;
    others  = m_pend;
    acc     = m_valid && evt_ready;
    for (int i = 0; i < WIDTH; i++) begin
      if (acc && m_idx == i) begin
        n_pend[i] = 1'b0;
        others[i] = 1'b0;
      end
      if (in_sig[i] && !m_in_q[i] && mask[i]) begin
        if (m_pend[i] && !(acc && m_idx == i)) n_ovf[i] = 1'b1;
        n_pend[i] = 1'b1;
      end
    end
    if (!m_valid) begin
      if (m_pend != 0) begin
        n_valid = 1'b1;
        n_idx   = search(m_pend, m_last);
      end
    end else if (acc) begin
      n_last = m_idx;
      if (others != 0) n_idx = search(others, m_idx);
      else n_valid = 1'b0;
    end
    if (clear) begin
      n_pend  = '0;
      n_ovf   = '0;
      n_valid = 1'b0;
      n_idx   = 0;
      n_last  = WIDTH - 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_q  <= '0;
      m_pend  <= '0;
      m_ovf   <= '0;
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_last  <= WIDTH - 1;
    end else begin
      m_in_q  <= n_in_q;
      m_pend  <= n_pend;
      m_ovf   <= n_ovf;
      m_valid <= n_valid;
      m_idx   <= n_idx;
      m_last  <= n_last;
    end
  end

  // Per-cycle comparison against the model, 2 time units after the edge.
  always begin
    @(posedge clk);
    #2;
    check("model_valid", 32'(evt_valid), 32'(m_valid));
    check("model_pending", 32'(pending), 32'(m_pend));
    check("model_overflow", 32'(overflow), 32'(m_ovf));
    if (m_valid) check("model_idx", 32'(evt_idx), 32'(m_idx[2:0]));
  end

  // Advance one edge; returns 3 time units after it, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  initial begin
    // 1: reset values, then two simultaneous rises
    mask = 8'hFF; evt_ready = 1'b1; in_sig = 8'h00;
    cyc(); cyc();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_idx", 32'(evt_idx), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    cyc();
    in_sig = 8'h0C;
    cyc();
    check("t1_pending", 32'(pending), 32'h0C);
    check("t1_valid_lat", 32'(evt_valid), 32'd0);
    cyc();
    check("t1_first_valid", 32'(evt_valid), 32'd1);
    check("t1_first_idx", 32'(evt_idx), 32'd2);
    cyc();
    check("t1_second_idx", 32'(evt_idx), 32'd3);
    cyc();
    check("t1_done_valid", 32'(evt_valid), 32'd0);
    check("t1_done_ovf", 32'(overflow), 32'd0);

    // 2: stalled offer, merge into overflow, single accept
    evt_ready = 1'b0;
    in_sig = 8'h0D; cyc();
    in_sig = 8'h0C; cyc();
    for (int k = 0; k < 5; k++) begin
      check("t2_hold_valid", 32'(evt_valid), 32'd1);
      check("t2_hold_idx", 32'(evt_idx), 32'd0);
      cyc();
    end
    in_sig = 8'h0D; cyc();
    in_sig = 8'h0C; cyc();
    check("t2_overflow", 32'(overflow), 32'h01);
    check("t2_pending", 32'(pending), 32'h01);
    evt_ready = 1'b1;
    cyc();
    check("t2_accept_valid", 32'(evt_valid), 32'd0);
    check("t2_sticky_ovf", 32'(overflow), 32'h01);
    cyc();
    check("t2_no_second", 32'(evt_valid), 32'd0);
    clear = 1'b1; cyc(); clear = 1'b0;
    check("t2_clear_ovf", 32'(overflow), 32'd0);
    check("t2_clear_idx", 32'(evt_idx), 32'd0);

    // 3: round robin after grant 5, then full sweep from grant 7
    in_sig = 8'h2C; cyc(); cyc();
    check("t3_idx5", 32'(evt_idx), 32'd5);
    cyc();
    in_sig = 8'h6E; cyc();
    check("t3_pending42", 32'(pending), 32'h42);
    cyc();
    check("t3_idx6", 32'(evt_idx), 32'd6);
    cyc();
    check("t3_idx1", 32'(evt_idx), 32'd1);
    cyc();
    check("t3_idle", 32'(evt_valid), 32'd0);
    in_sig = 8'h00; clear = 1'b1; cyc(); clear = 1'b0;
    in_sig = 8'hFF; cyc();
    for (int k = 0; k < WIDTH; k++) begin
      cyc();
      check("t3_sweep_idx", 32'(evt_idx), 32'(k));
    end
    cyc();
    check("t3_sweep_end", 32'(evt_valid), 32'd0);

    // 4: masked channels never capture
    mask = 8'hF0; in_sig = 8'h00; cyc();
    for (int j = 0; j < 6; j++) begin
      in_sig = (j % 2 == 0) ? 8'h0F : 8'h00;
      cyc();
      check("t4_masked_pend", 32'(pending), 32'd0);
    end
    in_sig = 8'h00; cyc();
    in_sig = 8'h4E; cyc();
    check("t4_pending40", 32'(pending), 32'h40);
    cyc();
    check("t4_idx6", 32'(evt_idx), 32'd6);
    cyc();
    check("t4_idle", 32'(evt_valid), 32'd0);
    mask = 8'hFF;

    // 5: rise during own accept, then clear beats a rise
    evt_ready = 1'b0; in_sig = 8'h00; cyc();
    in_sig = 8'h08; cyc();
    in_sig = 8'h00; cyc();
    check("t5_idx3", 32'(evt_idx), 32'd3);
    evt_ready = 1'b1; in_sig = 8'h08; cyc();
    check("t5_pend_kept", 32'(pending), 32'h08);
    check("t5_no_ovf", 32'(overflow), 32'd0);
    cyc();
    check("t5_reoffer_valid", 32'(evt_valid), 32'd1);
    check("t5_reoffer_idx", 32'(evt_idx), 32'd3);
    cyc();
    in_sig = 8'h18; clear = 1'b1; cyc(); clear = 1'b0;
    check("t5_clr_pending", 32'(pending), 32'd0);
    check("t5_clr_valid", 32'(evt_valid), 32'd0);
    cyc();
    check("t5_no_event", 32'(evt_valid), 32'd0);

    // 6: asynchronous reset mid-offer
    evt_ready = 1'b0; in_sig = 8'h00; cyc();
    in_sig = 8'h02; cyc(); cyc();
    check("t6_offer", 32'(evt_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(evt_valid), 32'd0);
    check("t6_async_pending", 32'(pending), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    check("t6_rise_after_rst", 32'(pending), 32'h02);
    cyc();
    check("t6_idx1", 32'(evt_idx), 32'd1);
    evt_ready = 1'b1;
    cyc();
    check("t6_idle", 32'(evt_valid), 32'd0);

    // Randomized traffic, checked by the per-cycle compare process
    for (int n = 0; n < 800; n++) begin
      in_sig    = 8'($urandom);
      mask      = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check("rnd_async_valid", 32'(evt_valid), 32'd0);
        #1 rst_n = 1'b1;
      end
      cyc();
    end
    clear = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel rising-edge event controller placed after the edge-detection datapath. It samples a WIDTH-bit input bus and latches a pending flag for each enabled channel that rises. It then presents the pending events one at a time, in round-robin order, on a valid/ready interface as a channel index. It also records a sticky overflow flag for any channel whose events were merged because the previous event had not yet been consumed.

## Interface
- WIDTH, 8, number of input channels
- IDXW, 3, index width; must equal clog2(WIDTH)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in  input  WIDTH  level inputs, one per channel
- mask  input  WIDTH  per-channel enable for edge capture; 1 = enabled
- clear  input  1  synchronous clear of pending, overflow, offer and pointer
- evt_ready  input  1  consumer accepts the offered event
- evt_valid  output  1  an event is offered
- evt_idx  output  IDXW  channel index of the offered event
- pending  output  WIDTH  registered pending flags
- overflow  output  WIDTH  sticky per-channel merge flags

Clock is clk. Reset is rst_n, asynchronous, active-low.

## Operation
- **Edge capture**
  - Register in_q holds the previous in; it updates every cycle, including during clear.
  - rise = in & ~in_q & mask.
- **Pending flags**
  - pending[i] sets on rise[i].
  - pending[i] clears on accept of channel i, where accept = evt_valid & evt_ready & (evt_idx == i).
  - If rise[i] and accept of channel i happen in the same cycle, pending[i] stays 1. This is a new event, and overflow is not set.
  - If rise[i] occurs while pending[i] = 1 and channel i is not being accepted, overflow[i] sets and the two events merge into one.
- **Mask**
  - mask gates capture only. Already-pending flags are unaffected by mask changes.
- **Offer FSM**
  - IDLE (evt_valid = 0): if pending != 0, select a winner and go to OFFER.
  - OFFER (evt_valid = 1): evt_idx is held stable until accept.
  - On accept: last_grant = evt_idx. If any other bit of the current pending register is set (accepted bit excluded), load the next winner and stay in OFFER, giving back-to-back offers. Otherwise go to IDLE.
- **Winner selection**
  - Search the current pending register starting at (last_grant + 1) mod WIDTH, ascending, with wrap-around.
  - Rises in the current cycle are visible to selection one cycle later.
- **Offer stability**
  - evt_valid never falls without an accept, except on clear or reset.
- **clear**
  - Has priority over rise and accept in the same cycle.
  - Next state: pending = 0, overflow = 0, evt_valid = 0, evt_idx = 0, last_grant = WIDTH-1.
- **Reset values**
  - in_q = 0, pending = 0, overflow = 0, evt_valid = 0, evt_idx = 0, last_grant = WIDTH-1, so channel 0 has first priority.
  - Because in_q resets to 0, an enabled input already high at the first clock edge after reset release counts as a rise.

## Timing
- **Latency from IDLE**
  - Rise sampled at edge k: pending[i] = 1 after edge k.
  - evt_valid = 1 and evt_idx = i after edge k+1.
- **Throughput**
  - One event per cycle while evt_ready = 1 and further channels are pending.
  - A channel newly set at the same edge as an accept is offered no earlier than the following edge.
- **Registered outputs**
  - All outputs are registered.
  - No combinational path from evt_ready to evt_valid or evt_idx.
- **Asynchronous reset**
  - Assertion of rst_n forces all outputs to their reset values immediately, with no clock required, including mid-offer.
  - Deassertion is used synchronously in the next cycle.

## Test plan
1. Reset, mask = 8'hFF, evt_ready = 1, in 0 -> 8'h0C and held -> pending = 8'h0C one edge later; evt_idx = 2 then 3 on consecutive cycles; evt_valid then 0; overflow = 0.
2. evt_ready = 0, one-cycle pulse on in[0] -> evt_valid = 1 and evt_idx = 0 stable for 5+ cycles. A second pulse on in[0] -> overflow = 8'h01. Raising evt_ready -> exactly one accept, then evt_valid = 0.
3. Round robin: accept channel 5 (last_grant = 5), then make pending = 8'h42 -> order 6 then 1. Pulse in = 8'hFF with last_grant = 7 -> order 0,1,...,7.
4. mask = 8'hF0, in toggles 0 <-> 8'h0F -> no events. in 0 -> 8'h4E -> only evt_idx = 6 is offered.
5. Rise on in[3] in the same cycle channel 3 is accepted -> pending[3] stays 1, a second event with evt_idx = 3 follows, overflow[3] = 0. clear asserted together with a rise on in[4] -> all state zero next cycle, no event.
6. Drive rst_n low during OFFER between clocks -> evt_valid and pending drop to 0 immediately. After release with in[1] high -> event with evt_idx = 1.
